gru_gate_scheduler: RTL and testbench

Sequencer for the VAD GRU gate computation. It walks the three gates (z, r, h) and 24 units in a fixed order, with N_UNIT = 24. For each (gate, unit) pair it issues bias, input-weight and recurrent-weight ROM reads using the flat packed weight layout, and drives the shared multiply-accumulate datapath with aligned control strobes. It then hands each finished pre-activation to the activation stage through a valid/ready handshake. It sits between the GRU weight ROMs and the single shared MAC.

---
 rtl/gru_gate_scheduler_if.sv | 39 +++
 rtl/gru_gate_scheduler.sv | 157 +++++++++++++++
 tb/tb_gru_gate_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gru_gate_scheduler_if.sv
// Handshake and ROM/MAC control bundle between the GRU gate scheduler
// and its environment (weight ROMs, shared MAC, activation stage).
interface gru_gate_scheduler_if #(
  parameter int BW = 7,
  parameter int AW = 11
);
  logic          start;
  logic          busy;
  logic          done;
  logic          bias_rd;
  logic [BW-1:0] bias_addr;
  logic          w_rd;
  logic          w_sel;
  logic [AW-1:0] w_addr;
  logic          mac_load;
  logic          mac_en;
  logic          mac_last;
  logic          vec_sel;
  logic [4:0]    vec_idx;
  logic          rec_gated;
  logic [1:0]    gate;
  logic [4:0]    unit;
  logic          res_valid;
  logic          res_ready;

  modport master (
    input  start, res_ready,
    output busy, done, bias_rd, bias_addr, w_rd, w_sel, w_addr,
           mac_load, mac_en, mac_last, vec_sel, vec_idx, rec_gated,
           gate, unit, res_valid
  );

  modport slave (
    output start, res_ready,
    input  busy, done, bias_rd, bias_addr, w_rd, w_sel, w_addr,
           mac_load, mac_en, mac_last, vec_sel, vec_idx, rec_gated,
           gate, unit, res_valid
  );
endinterface

// File: rtl/gru_gate_scheduler.sv
// Walks gates z,r,h over all units, issuing bias/weight ROM reads and
// ROM-aligned MAC strobes, then offers each pre-activation via valid/ready.
module gru_gate_scheduler #(
  parameter int N_IN   = 24,
  parameter int N_UNIT = 24,
  parameter int BW     = 7,
  parameter int AW     = 11
) (
  input logic clk,
  input logic rst,
  gru_gate_scheduler_if.master sch
);

  localparam int C_LAST = N_IN + N_UNIT;
  localparam int CW     = $clog2(C_LAST + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [1:0]    g_q, g_d;
  logic [4:0]    u_q, u_d;
  logic [4:0]    k_q, k_d;
  logic          last_unit;
  logic          issue_d;

  logic          busy_q, done_q, bias_rd_q, w_rd_q, w_sel_q;
  logic [BW-1:0] bias_addr_q;
  logic [AW-1:0] w_addr_q;
  logic          mac_load_q, mac_en_q, mac_last_q, vec_sel_q, rec_gated_q;
  logic [4:0]    vec_idx_q;
  logic          res_valid_q;

  assign last_unit = (g_q == 2'd2) && (u_q == 5'(N_UNIT - 1));
  assign issue_d   = (state_d == S_ISSUE);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    g_d     = g_q;
    u_d     = u_q;
    case (state_q)
      S_IDLE: begin
        if (sch.start) begin
          state_d = S_ISSUE;
          c_d     = '0;
          g_d     = 2'd0;
          u_d     = 5'd0;
        end
      end
      S_ISSUE: begin
        if (c_q == CW'(C_LAST)) begin
          state_d = S_DRAIN;
          c_d     = '0;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DRAIN: state_d = S_RESULT;
      S_RESULT: begin
        if (sch.res_ready) begin
          c_d = '0;
          if (last_unit) begin
            state_d = S_IDLE;
            g_d     = 2'd0;
            u_d     = 5'd0;
          end else if (u_q == 5'(N_UNIT - 1)) begin
            state_d = S_ISSUE;
            g_d     = g_q + 2'd1;
            u_d     = 5'd0;
          end else begin
            state_d = S_ISSUE;
            u_d     = u_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Step 0 is the bias read; steps 1..N_IN input terms, the rest recurrent.
  always_comb begin
    k_d = 5'd0;
    if (c_d == '0)
      k_d = 5'd0;
    else if (c_d <= CW'(N_IN))
      k_d = 5'(c_d - CW'(1));
    else
      k_d = 5'(c_d - CW'(N_IN + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      g_q         <= 2'd0;
      u_q         <= 5'd0;
      k_q         <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bias_rd_q   <= 1'b0;
      bias_addr_q <= '0;
      w_rd_q      <= 1'b0;
      w_sel_q     <= 1'b0;
      w_addr_q    <= '0;
      mac_load_q  <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_last_q  <= 1'b0;
      vec_sel_q   <= 1'b0;
      vec_idx_q   <= 5'd0;
      rec_gated_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      g_q         <= g_d;
      u_q         <= u_d;
      k_q         <= k_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_q == S_RESULT) && sch.res_ready && last_unit;
      bias_rd_q   <= issue_d && (c_d == '0);
      bias_addr_q <= BW'(g_d) * BW'(N_UNIT) + BW'(u_d);
      w_rd_q      <= issue_d && (c_d != '0);
      w_sel_q     <= issue_d && (c_d > CW'(N_IN));
      w_addr_q    <= AW'(k_d) * AW'(3 * N_UNIT) + AW'(g_d) * AW'(N_UNIT) + AW'(u_d);
      // MAC controls trail the ROM strobes by the one-cycle read latency.
      mac_load_q  <= bias_rd_q;
      mac_en_q    <= w_rd_q;
      vec_sel_q   <= w_sel_q;
      vec_idx_q   <= k_q;
      rec_gated_q <= w_rd_q && w_sel_q && (g_q == 2'd2);
      mac_last_q  <= w_rd_q && w_sel_q && (k_q == 5'(N_UNIT - 1));
      res_valid_q <= (state_d == S_RESULT);
    end
  end

  assign sch.busy      = busy_q;
  assign sch.done      = done_q;
  assign sch.bias_rd   = bias_rd_q;
  assign sch.bias_addr = bias_addr_q;
  assign sch.w_rd      = w_rd_q;
  assign sch.w_sel     = w_sel_q;
  assign sch.w_addr    = w_addr_q;
  assign sch.mac_load  = mac_load_q;
  assign sch.mac_en    = mac_en_q;
  assign sch.mac_last  = mac_last_q;
  assign sch.vec_sel   = vec_sel_q;
  assign sch.vec_idx   = vec_idx_q;
  assign sch.rec_gated = rec_gated_q;
  assign sch.gate      = g_q;
  assign sch.unit      = u_q;
  assign sch.res_valid = res_valid_q;

endmodule

// File: tb/tb_gru_gate_scheduler.sv
// Scoreboard bench: an arithmetic model of the (gate, unit, k) walk feeds
// expected ROM reads, MAC strobes and results; a monitor pops and compares.
module tb_gru_gate_scheduler;
  localparam int NI = 24;
  localparam int NU = 24;
  localparam int STEP_CYC = 3 * NU * (NI + NU + 3) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int exp_rd[$];
  int exp_mac[$];
  int exp_res[$];

  int max_b = 0;
  int max_w = 0;
  int seen171 = 0;
  bit prev_stall = 1'b0;
  int pg = 0;
  int pu = 0;

  gru_gate_scheduler_if #(.BW(7), .AW(11)) sch ();

  gru_gate_scheduler #(.N_IN(NI), .N_UNIT(NU), .BW(7), .AW(11)) dut (
    .clk(clk),
    .rst(rst),
    .sch(sch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int nz_count();
    return int'(sch.busy) + int'(sch.done) + int'(sch.bias_rd) + int'(sch.bias_addr != 0)
         + int'(sch.w_rd) + int'(sch.w_sel) + int'(sch.w_addr != 0) + int'(sch.mac_load)
         + int'(sch.mac_en) + int'(sch.mac_last) + int'(sch.vec_sel) + int'(sch.vec_idx != 0)
         + int'(sch.rec_gated) + int'(sch.gate != 0) + int'(sch.unit != 0) + int'(sch.res_valid);
  endfunction

  // Reference walk: for every (g,u), bias read, NI input terms, NU recurrent terms, one result.
  task automatic push_step();
    for (int g = 0; g < 3; g++) begin
      for (int u = 0; u < NU; u++) begin
        exp_rd.push_back((1 << 13) | (g * NU + u));
        for (int k = 0; k < NI; k++) exp_rd.push_back((1 << 12) | (k * 3 * NU + g * NU + u));
        for (int k = 0; k < NU; k++)
          exp_rd.push_back((1 << 12) | (1 << 11) | (k * 3 * NU + g * NU + u));
        exp_mac.push_back(1 << 10);
        for (int k = 0; k < NI; k++) exp_mac.push_back((1 << 9) | k);
        for (int k = 0; k < NU; k++)
          exp_mac.push_back((1 << 9) | (int'(k == NU - 1) << 8) | (int'(g == 2) << 7) | (1 << 6) | k);
        exp_res.push_back(g * 32 + u);
      end
    end
  endtask

  always @(negedge clk) begin
    int act;
    int e;
    #1;
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (sch.bias_rd || sch.w_rd) begin
        act = (int'(sch.bias_rd) << 13) | (int'(sch.w_rd) << 12) | (int'(sch.w_sel) << 11)
            | (sch.bias_rd ? int'(sch.bias_addr) : int'(sch.w_addr));
        if (sch.bias_rd && int'(sch.bias_addr) > max_b) max_b = int'(sch.bias_addr);
        if (sch.w_rd && int'(sch.w_addr) > max_w) max_w = int'(sch.w_addr);
        if (sch.w_rd && !sch.w_sel && sch.gate == 2'd1 && sch.unit == 5'd3 && sch.w_addr == 11'd171)
          seen171++;
        if (exp_rd.size() == 0) check(1'b0, "rd_unexpected", act, -1);
        else begin
          e = exp_rd.pop_front();
          check(act == e, "rom_read", act, e);
        end
      end
      if (sch.mac_load || sch.mac_en || sch.mac_last || sch.rec_gated) begin
        act = (int'(sch.mac_load) << 10) | (int'(sch.mac_en) << 9) | (int'(sch.mac_last) << 8)
            | (int'(sch.rec_gated) << 7) | (int'(sch.vec_sel) << 6) | int'(sch.vec_idx);
        if (exp_mac.size() == 0) check(1'b0, "mac_unexpected", act, -1);
        else begin
          e = exp_mac.pop_front();
          if (e == (1 << 10)) check((act >> 7) == (e >> 7), "mac_load", act, e);
          else check(act == e, "mac_term", act, e);
        end
      end
      if (sch.res_valid) begin
        act = int'(sch.bias_rd) + int'(sch.w_rd) + int'(sch.mac_en) + int'(sch.mac_load);
        check(act == 0, "result_quiet", act, 0);
      end
      if (prev_stall) begin
        act = int'(sch.res_valid) * 1024 + int'(sch.gate) * 32 + int'(sch.unit);
        check(act == 1024 + pg * 32 + pu, "stall_hold", act, 1024 + pg * 32 + pu);
      end
      if (sch.res_valid && sch.res_ready) begin
        act = int'(sch.gate) * 32 + int'(sch.unit);
        if (exp_res.size() == 0) check(1'b0, "res_unexpected", act, -1);
        else begin
          e = exp_res.pop_front();
          check(act == e, "result_order", act, e);
        end
      end
      if (sch.done) check(exp_res.size() == 0 && !sch.busy, "done_state", exp_res.size(), 0);
      prev_stall = sch.res_valid && !sch.res_ready;
      pg = int'(sch.gate);
      pu = int'(sch.unit);
    end
  end

  task automatic do_start(output int t0);
    push_step();
    sch.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    sch.start = 1'b0;
    check(sch.busy && sch.bias_rd && sch.bias_addr == 0 && sch.gate == 0 && sch.unit == 0,
          "start_t1", nz_count(), 2);
  endtask

  task automatic run_step(input bit rnd, input int sg, input int su, input int slen, input int t0);
    int  fl = -1, fm = -1, fr = -1, done_cyc = -1, left = 0, stalls = 0, expd;
    bit  stalled = 1'b0, seen = 1'b0;
    for (int n = 0; n < 8000 && !seen; n++) begin
      if (sch.mac_load && fl < 0) fl = cyc;
      if (sch.mac_last && fm < 0) fm = cyc;
      if (sch.res_valid && fr < 0) fr = cyc;
      if (sch.done) begin seen = 1'b1; done_cyc = cyc; end
      if (left > 0) begin
        sch.res_ready = 1'b0;
        left--;
      end else if (slen > 0 && !stalled && sch.res_valid && int'(sch.gate) == sg && int'(sch.unit) == su) begin
        stalled = 1'b1;
        sch.res_ready = 1'b0;
        left = slen - 1;
      end else begin
        sch.res_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (sch.res_valid && !sch.res_ready) stalls++;
      sch.start = rnd && sch.busy && ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    sch.start = 1'b0;
    sch.res_ready = 1'b1;
    check(seen, "done_timeout", int'(seen), 1);
    check(fl == t0 + 2, "mac_load_time", fl - t0, 2);
    check(fm == t0 + 50, "mac_last_time", fm - t0, 50);
    check(fr == t0 + 51, "res_valid_time", fr - t0, 51);
    if (!rnd) check(stalls == slen, "stall_count", stalls, slen);
    expd = t0 + STEP_CYC + (rnd ? stalls : slen);
    check(done_cyc == expd, "done_time", done_cyc - t0, expd - t0);
    check(exp_rd.size() + exp_mac.size() + exp_res.size() == 0, "queues_drained",
          exp_rd.size() + exp_mac.size() + exp_res.size(), 0);
  endtask

  initial begin
    int  t0;
    bit  pulsed, hit;
    sch.start = 1'b0;
    sch.res_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check(nz_count() == 0, "reset_outputs", nz_count(), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(nz_count() == 0, "idle_outputs", nz_count(), 0);
    end

    // Full step with ready held high; also covers the single-unit trace and address corners.
    do_start(t0);
    run_step(1'b0, 0, 0, 0, t0);
    check(max_b == 71, "bias_addr_max", max_b, 71);
    check(max_w == 1727, "w_addr_max", max_w, 1727);
    check(seen171 == 1, "w_addr_g1u3k2", seen171, 1);

    repeat ($urandom_range(1, 5)) @(negedge clk);
    do_start(t0);
    run_step(1'b0, 1, 5, 20, t0);

    repeat ($urandom_range(1, 5)) @(negedge clk);
    do_start(t0);
    run_step(1'b1, 0, 0, 0, t0);

    // Start while busy, then reset mid-run.
    @(negedge clk);
    do_start(t0);
    pulsed = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 6000 && !hit; n++) begin
      if (sch.gate == 2'd2 && sch.unit == 5'd4) hit = 1'b1;
      else begin
        sch.start = !pulsed && sch.bias_rd && sch.gate == 2'd0 && sch.unit == 5'd10;
        if (sch.start) pulsed = 1'b1;
        @(negedge clk);
      end
    end
    sch.start = 1'b0;
    check(hit && pulsed, "reach_g2u4", int'(hit) + int'(pulsed), 2);
    rst = 1'b1;
    @(negedge clk);
    check(nz_count() == 0, "midrun_reset", nz_count(), 0);
    exp_rd.delete();
    exp_mac.delete();
    exp_res.delete();
    rst = 1'b0;
    @(negedge clk);
    check(nz_count() == 0 && !sch.busy, "post_reset_idle", nz_count(), 0);
    do_start(t0);
    run_step(1'b0, 0, 0, 0, t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
